// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Non-pipelined fetch/issue unit. Owns the PC, fetches one word
//            per instruction over a req/valid memory handshake, issues it for
//            one cycle with decoded field slices and reacts to the control
//            unit's pc_sel / inst_sel (advance, jump, hold, squash, replay).
// Options  : FETCH_MISALIGN_CHK_EN - jumps to non-word-aligned targets raise
//            fetch_err instead of silently clearing jump_addr[1:0].
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_sel,
    input  logic [1:0]  inst_sel,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_WAIT  = 2'd1;
    localparam logic [1:0] C_ST_ISSUE = 2'd2;
    localparam logic [1:0] C_ST_ERR   = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [31:0]      pc_q,        pc_d;
    logic [31:0]      inst_q,      inst_d;
    logic [31:0]      pc_out_q,    pc_out_d;
    logic             fetch_err_q, fetch_err_d;
    logic             squash_q,    squash_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;

    logic [31:0]      w_jump_tgt;
    logic [31:0]      w_pc_next;
    logic             w_misalign;

    // State register: every flop of the unit, reset wins over all events
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= C_ST_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            pc_out_q    <= RESET_PC;
            fetch_err_q <= 1'b0;
            squash_q    <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            pc_out_q    <= pc_out_d;
            fetch_err_q <= fetch_err_d;
            squash_q    <= squash_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Next-state and datapath: fetch handshake, timeout, PC selection
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        pc_out_d    = pc_out_q;
        fetch_err_d = fetch_err_q;
        squash_d    = squash_q;
        wait_cnt_d  = wait_cnt_q;

        // Masking (rather than slicing) keeps every jump_addr bit in use
        w_jump_tgt = jump_addr & 32'hFFFF_FFFC;
        case (pc_sel)
            2'b00:   w_pc_next = w_jump_tgt;
            2'b10:   w_pc_next = pc_q;
            default: w_pc_next = pc_q + 32'd4;
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        w_misalign = (pc_sel == 2'b00) && (jump_addr[1:0] != 2'b00);
`else
        w_misalign = 1'b0;
`endif

        case (state_q)
            C_ST_IDLE: begin
                state_d    = C_ST_WAIT;
                wait_cnt_d = '0;
            end
            C_ST_WAIT: begin
                if (imem_valid) begin
                    // A pending squash swaps the fetched word for a NOP
                    inst_d     = squash_q ? NOP_INST : imem_rdata;
                    squash_d   = 1'b0;
                    pc_out_d   = pc_q;
                    wait_cnt_d = '0;
                    state_d    = C_ST_ISSUE;
                end else if (wait_cnt_q == C_WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = C_ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            C_ST_ISSUE: begin
                if (w_misalign) begin
                    fetch_err_d = 1'b1;
                    state_d     = C_ST_ERR;
                end else begin
                    pc_d = w_pc_next;
                    case (inst_sel)
                        2'b01: begin
                            squash_d = 1'b1;
                            state_d  = C_ST_WAIT;
                        end
                        2'b10: begin
                            // Replay keeps the word but reports the updated PC
                            pc_out_d = w_pc_next;
                            state_d  = C_ST_ISSUE;
                        end
                        default: state_d = C_ST_WAIT;
                    endcase
                end
            end
            C_ST_ERR: begin
                state_d = C_ST_ERR;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // Outputs: handshake strobes decoded from state, data from registers
    always_comb begin
        imem_req   = (state_q == C_ST_WAIT);
        inst_valid = (state_q == C_ST_ISSUE);
        imem_addr  = pc_q;
        inst       = inst_q;
        pc_out     = pc_out_q;
        fetch_err  = fetch_err_q;
        opcode     = inst_q[6:2];
        func3      = inst_q[14:12];
        func7      = inst_q[31:25];
        rd         = inst_q[11:7];
        rs1        = inst_q[19:15];
        rs2        = inst_q[24:20];
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Scoreboard bench for inst_fetch: directed fetch/issue sequences
//            with hand-computed issue words, PCs and fetch addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    typedef struct packed {
        logic [1:0]  ps;
        logic [1:0]  is;
        logic [31:0] ja;
    } act_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_sel;
    logic [1:0]  inst_sel;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fetch_err;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    act_t act_q[$];
    logic [31:0] addr_q[$];

    logic resp_en;
    logic force_valid;
    int   resp_delay;
    int   req_cnt;

    inst_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc_sel     (pc_sel),
        .inst_sel   (inst_sel),
        .jump_addr  (jump_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc_out     (pc_out),
        .opcode     (opcode),
        .func3      (func3),
        .func7      (func7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h0050_0093;  // addi x1,x0,5
            32'h04: return 32'h00A0_0113;  // addi x2,x0,10
            32'h08: return 32'h00F0_0193;  // addi x3,x0,15
            32'h0C: return 32'h0020_81B3;  // add  x3,x1,x2
            32'h40: return 32'h4020_8233;  // sub  x4,x1,x2
            default: return 32'h0000_0073;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_issue(input logic [31:0] i, input logic [31:0] p,
                              input logic [1:0] ps, input logic [1:0] is,
                              input logic [31:0] ja);
        exp_q.push_back('{inst: i, pc: p});
        act_q.push_back('{ps: ps, is: is, ja: ja});
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Memory model: answers requests after resp_delay wait cycles
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        req_cnt    = 0;
        forever begin
            @(negedge clk);
            if (force_valid) begin
                imem_valid = 1'b1;
                imem_rdata = 32'h0000_0093;
            end else if (imem_req && resp_en) begin
                req_cnt++;
                if (req_cnt > resp_delay) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    imem_valid = 1'b0;
                end
            end else begin
                imem_valid = 1'b0;
                if (!imem_req) req_cnt = 0;
            end
        end
    end

    // Control driver: applies the next queued pc_sel/inst_sel in each issue cycle
    initial begin
        pc_sel    = 2'b01;
        inst_sel  = 2'b00;
        jump_addr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (inst_valid && act_q.size() != 0) begin
                act_t a;
                a = act_q.pop_front();
                pc_sel    = a.ps;
                inst_sel  = a.is;
                jump_addr = a.ja;
            end
        end
    end

    // Issue monitor
    initial begin
        forever begin
            @(negedge clk);
            if (inst_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", inst, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("issue_inst",   inst,   e.inst);
                    check("issue_pc",     pc_out, e.pc);
                    check("issue_opcode", {27'h0, opcode}, {27'h0, e.inst[6:2]});
                    check("issue_func3",  {29'h0, func3},  {29'h0, e.inst[14:12]});
                    check("issue_func7",  {25'h0, func7},  {25'h0, e.inst[31:25]});
                    check("issue_rd",     {27'h0, rd},     {27'h0, e.inst[11:7]});
                    check("issue_rs1",    {27'h0, rs1},    {27'h0, e.inst[19:15]});
                    check("issue_rs2",    {27'h0, rs2},    {27'h0, e.inst[24:20]});
                    check("issue_req_low", {31'h0, imem_req}, 32'h0);
                end
            end
        end
    end

    // Fetch-address monitor: one expected address per request rising edge
    initial begin
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req && !req_prev) begin
                if (addr_q.size() == 0)
                    check("unexpected_req", imem_addr, 32'hFFFF_FFFF);
                else
                    check("fetch_addr", imem_addr, addr_q.pop_front());
            end
            req_prev = imem_req;
        end
    end

    // Stimulus
    initial begin
        int cnt;
        rst         = 1'b1;
        resp_en     = 1'b1;
        force_valid = 1'b0;
        resp_delay  = 1;
        repeat (3) @(negedge clk);
        check("rst_req",   {31'h0, imem_req},   32'h0);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst",  inst,                32'h0000_0013);
        check("rst_pc",    pc_out,              32'h0);
        check("rst_err",   {31'h0, fetch_err},  32'h0);

        // Sequential fetch, squash, hold+replay, jump, advance+replay, misaligned jump
        addr_q.push_back(32'h00);
        addr_q.push_back(32'h04);
        addr_q.push_back(32'h08);
        addr_q.push_back(32'h0C);
        addr_q.push_back(32'h40);
        push_issue(32'h0050_0093, 32'h00, 2'b01, 2'b00, 32'h0);
        push_issue(32'h00A0_0113, 32'h04, 2'b01, 2'b01, 32'h0);
        push_issue(32'h0000_0013, 32'h08, 2'b01, 2'b00, 32'h0);
        push_issue(32'h0020_81B3, 32'h0C, 2'b10, 2'b10, 32'h0);
        push_issue(32'h0020_81B3, 32'h0C, 2'b00, 2'b00, 32'h40);
        push_issue(32'h4020_8233, 32'h40, 2'b01, 2'b10, 32'h0);
        push_issue(32'h4020_8233, 32'h44, 2'b00, 2'b00, 32'h42);
        rst = 1'b0;
        drain(200);
        resp_delay = 0;

`ifdef FETCH_MISALIGN_CHK_EN
        @(negedge clk);
        check("misalign_err", {31'h0, fetch_err}, 32'h1);
        check("misalign_req", {31'h0, imem_req},  32'h0);
        @(negedge clk);
        check("misalign_req_hold", {31'h0, imem_req}, 32'h0);
        #1 rst = 1'b1;
        addr_q.push_back(32'h00);
        addr_q.push_back(32'h40);
        push_issue(32'h0050_0093, 32'h00, 2'b00, 2'b00, 32'h40);
        @(negedge clk);
        rst = 1'b0;
        drain(100);
`else
        addr_q.push_back(32'h40);
        addr_q.push_back(32'h40);
        push_issue(32'h4020_8233, 32'h40, 2'b00, 2'b00, 32'h40);
        drain(100);
`endif
        // Reset in the middle of a WAIT at 0x40
        resp_en = 1'b0;
        @(negedge clk);
        check("midwait_req",  {31'h0, imem_req}, 32'h1);
        check("midwait_addr", imem_addr,         32'h40);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_req", {31'h0, imem_req},   32'h0);
        check("midrst_pc",  pc_out,              32'h0);
        check("midrst_vld", {31'h0, inst_valid}, 32'h0);
        check("midrst_err", {31'h0, fetch_err},  32'h0);
        addr_q.push_back(32'h00);
        addr_q.push_back(32'h04);
        push_issue(32'h0050_0093, 32'h00, 2'b01, 2'b00, 32'h0);
        rst     = 1'b0;
        resp_en = 1'b1;
        drain(100);

        // Withhold the response at 0x4 until the timeout fires
        resp_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_err) break;
            if (imem_req) cnt++;
        end
        check("timeout_cycles", cnt,                 32'd16);
        check("timeout_err",    {31'h0, fetch_err},  32'h1);
        check("timeout_req",    {31'h0, imem_req},   32'h0);
        force_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_valid_ignored", {31'h0, inst_valid}, 32'h0);
        end
        force_valid = 1'b0;
        @(negedge clk);
        check("err_sticky", {31'h0, fetch_err}, 32'h1);
        check("addr_q_empty", addr_q.size(), 32'h0);
        check("exp_q_empty",  exp_q.size(),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
